// File: rtl/pipe_pkg.sv
// Shared pipeline-stage widths and control-field layout.
// Every stage slices ctrl with these indices.
package pipe_pkg;
  localparam int DATA_W_DEF = 37;
  localparam int CTRL_W_DEF = 6;
  localparam int CTRL_REG_WE = 0;
  localparam int CTRL_MEM_WE = 1;
  localparam int CTRL_MEM_TYPE = 2;
  localparam int CTRL_WB_SEL_LSB = 3;
  localparam int CTRL_WB_SEL_MSB = 4;
endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear wins over a coincident increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // count up, hold at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with optional skid slot,
// flush, ctrl bubble masking and a stall counter.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              live;
  logic              acc;
  logic              drn;
  logic              main_valid;
  logic              main_valid_n;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic              skid_valid_n;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              ld_in;
  logic              ld_skid;
  logic              ld_from_skid;

  assign acc       = in_valid & in_ready;
  assign drn       = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};

  // holds in_ready low until the first edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  // occupancy next-state; flush overrides everything
  always_comb begin
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    ld_in        = 1'b0;
    ld_skid      = 1'b0;
    ld_from_skid = 1'b0;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (skid_valid && drn) begin
      ld_from_skid = 1'b1;
      skid_valid_n = 1'b0;
    end else if (acc && (!main_valid || drn)) begin
      ld_in        = 1'b1;
      main_valid_n = 1'b1;
    end else if (acc) begin
      ld_skid      = 1'b1;
      skid_valid_n = 1'b1;
    end else if (drn) begin
      main_valid_n = 1'b0;
    end
  end

  // main entry: loads only on accept or skid transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
    end else begin
      main_valid <= main_valid_n;
      if (ld_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (ld_from_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = live & ~skid_valid;

      // skid entry catches the beat in flight when main stalls
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          skid_valid <= 1'b0;
          skid_data  <= '0;
          skid_ctrl  <= '0;
        end else begin
          skid_valid <= skid_valid_n;
          if (ld_skid) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
          end
        end
      end
    end else begin : g_noskid
      assign in_ready   = live & (~main_valid | out_ready);
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
    end
  endgenerate

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall (
    .clk(clk),
    .rst(rst),
    .inc(main_valid & ~out_ready),
    .clr(stat_clr),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed plus random bench for pipe_stage_hs:
// SKID=1, SKID=0 and a 4-bit-counter instance share stimulus.
module tb_pipe_stage_hs;

  localparam int DW = 37;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          stat_clr = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;

  logic          ir [3];
  logic          ov [3];
  logic [DW-1:0] od [3];
  logic [CW-1:0] oc [3];
  logic [15:0]   sc_a;
  logic [15:0]   sc_b;
  logic [3:0]    sc_c;

  int nchk = 0;
  int nfail = 0;

  logic [DW+CW-1:0] sb [3][4];
  int hd [3];
  int tl [3];
  int n  [3];

  always #5 clk = ~clk;

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_ctrl(oc[0]),
    .flush(flush), .stat_clr(stat_clr), .stall_cnt(sc_a)
  );

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_ctrl(oc[1]),
    .flush(flush), .stat_clr(stat_clr), .stall_cnt(sc_b)
  );

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_ctrl(oc[2]),
    .flush(flush), .stat_clr(stat_clr), .stall_cnt(sc_c)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: evaluates the upcoming edge from mid-cycle values
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        hd[k] = 0;
        tl[k] = 0;
        n[k]  = 0;
      end else begin
        if (!ov[k]) chk("bubble_ctrl", 64'(oc[k]), 64'd0);
        if (ov[k] && out_ready) begin
          chk("sb_have", 64'(n[k] != 0), 64'd1);
          if (n[k] != 0) begin
            chk("sb_order", 64'({od[k], oc[k]}), 64'(sb[k][hd[k]]));
            hd[k] = (hd[k] + 1) % 4;
            n[k]  = n[k] - 1;
          end
        end
        if (flush) begin
          hd[k] = 0;
          tl[k] = 0;
          n[k]  = 0;
        end else if (in_valid && ir[k]) begin
          sb[k][tl[k]] = {in_data, in_ctrl};
          tl[k] = (tl[k] + 1) % 4;
          n[k]  = n[k] + 1;
        end
      end
    end
  end

  initial begin
    #3;
    chk("rst_in_ready", 64'(ir[0]), 64'd0);
    chk("rst_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_stall", 64'(sc_a), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("rel_in_ready", 64'(ir[0]), 64'd1);

    in_valid = 1'b1;
    in_data  = DW'(37'h1234);
    in_ctrl  = 6'h3F;
    step();
    in_valid = 1'b0;
    chk("fill_valid", 64'(ov[0]), 64'd1);
    chk("fill_data", 64'(od[0]), 64'h1234);
    chk("fill_ctrl", 64'(oc[0]), 64'h3F);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(ov[0]), 64'd0);
    chk("midrst_ctrl", 64'(oc[0]), 64'd0);
    chk("midrst_ready", 64'(ir[0]), 64'd0);
    chk("midrst_stall", 64'(sc_a), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("rel2_in_ready", 64'(ir[0]), 64'd1);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(1);
    in_ctrl   = CW'(1);
    step();
    in_data = DW'(2);
    in_ctrl = CW'(2);
    chk("bp_ready_a", 64'(ir[0]), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_ready_low", 64'(ir[0]), 64'd0);
    chk("bp_head_a", 64'(od[0]), 64'd1);
    chk("bp_stall1", 64'(sc_a), 64'd1);
    step();
    out_ready = 1'b1;
    chk("bp_head_hold", 64'({ov[0], od[0]}), 64'({1'b1, DW'(1)}));
    step();
    chk("bp_head_b", 64'({ov[0], od[0]}), 64'({1'b1, DW'(2)}));
    chk("bp_ready_back", 64'(ir[0]), 64'd1);
    step();
    chk("bp_empty", 64'(ov[0]), 64'd0);
    chk("bp_stall2", 64'(sc_a), 64'd2);
    chk("bp_stall2_c", 64'(sc_c), 64'd2);

    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_a", 64'(sc_a), 64'd0);
    chk("clr_b", 64'(sc_b), 64'd0);

    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      in_ctrl  = CW'(i);
      step();
      chk("tp_a", 64'({ov[0], od[0]}), 64'({1'b1, DW'(i)}));
      chk("tp_b", 64'({ov[1], od[1]}), 64'({1'b1, DW'(i)}));
    end
    in_valid = 1'b0;
    step();
    chk("tp_a_empty", 64'(ov[0]), 64'd0);
    chk("tp_b_empty", 64'(ov[1]), 64'd0);
    chk("tp_stall_a", 64'(sc_a), 64'd0);
    chk("tp_stall_b", 64'(sc_b), 64'd0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(37'h10);
    in_ctrl   = 6'h01;
    step();
    in_data = DW'(37'h11);
    in_ctrl = 6'h02;
    step();
    chk("fl_full", 64'(ir[0]), 64'd0);
    in_data = DW'(37'h99);
    in_ctrl = 6'h3F;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(ov[0]), 64'd0);
    chk("fl_ctrl", 64'(oc[0]), 64'd0);
    chk("fl_ready", 64'(ir[0]), 64'd1);
    in_valid = 1'b1;
    in_data  = DW'(37'h55);
    in_ctrl  = 6'h05;
    step();
    in_valid = 1'b0;
    chk("fl_next", 64'({ov[0], od[0], oc[0]}), 64'({1'b1, DW'(37'h55), 6'h05}));
    out_ready = 1'b1;
    step();
    chk("fl_drained", 64'(ov[0]), 64'd0);
    chk("fl_stall", 64'(sc_a), 64'd2);
    in_valid = 1'b1;
    in_data  = DW'(37'h77);
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl2_a", 64'(ov[0]), 64'd0);
    chk("fl2_b", 64'(ov[1]), 64'd0);

    stat_clr = 1'b1;
    step();
    stat_clr  = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(37'hAA);
    step();
    in_valid = 1'b0;
    repeat (20) step();
    chk("sat_c", 64'(sc_c), 64'd15);
    chk("sat_a", 64'(sc_a), 64'd20);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("satclr_c", 64'(sc_c), 64'd0);
    chk("satclr_a", 64'(sc_a), 64'd0);
    step();
    chk("satinc_c", 64'(sc_c), 64'd1);
    out_ready = 1'b1;
    step();

    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = DW'({$urandom(), $urandom()});
      in_ctrl   = CW'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("rnd_end_a", 64'(ov[0]), 64'd0);
    chk("rnd_end_b", 64'(ov[1]), 64'd0);
    chk("rnd_end_c", 64'(ov[2]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
Parametrised pipeline-stage register that generalises the fixed EX/MEM latch. It carries a data payload and a separate control field between any two pipeline stages. It uses a valid/ready handshake, an optional 2-entry skid buffer for full throughput under backpressure, and flush with control squash. It also keeps a saturating backpressure-stall counter for performance monitoring.

Parameters:
DATA_W, 37, payload width in bits (e.g. alu result plus rd plus rs2 fields).
CTRL_W, 6, control-field width in bits; forced to zero whenever the stage holds no valid entry.
SKID, 1, 1 = two entries (main plus skid) with registered in_ready; 0 = single entry with combinational in_ready.
CNT_W, 16, stall counter width in bits.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  upstream has a beat.
in_ready  out  1  stage can accept a beat.
in_data  in  DATA_W  upstream payload.
in_ctrl  in  CTRL_W  upstream control bits.
out_valid  out  1  stage presents a beat.
out_ready  in  1  downstream accepts.
out_data  out  DATA_W  payload of the oldest entry.
out_ctrl  out  CTRL_W  control of the oldest entry, masked by out_valid.
flush  in  1  kill all entries (branch mispredict or trap).
stat_clr  in  1  synchronous clear of the stall counter.
stall_cnt  out  CNT_W  saturating count of backpressure cycles.

Behaviour:
- Handshake events:
  - Accept happens when in_valid && in_ready.
  - Drain happens when out_valid && out_ready.
- Reset (async, active-high):
  - main_valid, skid_valid, stored data, stored ctrl and stall_cnt all clear to 0 immediately.
  - in_ready is driven 0 while rst is high and rises the first cycle after deassertion.
  - Reset mid-transfer loses in-flight beats without any partial output.
- Latency:
  - One cycle from accept to out_valid when the stage was empty.
  - Back-to-back accept and drain every cycle sustains one beat per cycle in both SKID modes.
- SKID=1:
  - in_ready = ~skid_valid, a registered signal with no combinational path from out_ready.
  - Accept when main is empty, or when main drains this cycle with skid empty: the beat loads into main.
  - Accept when main is full and not draining: the beat loads into skid.
  - Drain with skid full: skid moves to main and skid_valid clears. Any accept that same cycle is impossible because in_ready is 0.
  - Ordering is strictly FIFO; out_* always reflects main.
- SKID=0:
  - in_ready = ~main_valid | out_ready, a combinational path.
  - No skid register is instantiated.
- Flush:
  - Has priority over every other event in the same cycle.
  - Next cycle main_valid = 0 and skid_valid = 0.
  - A beat offered with in_ready high during the flush cycle counts as consumed and is discarded.
  - A drain coinciding with flush still counts as completed downstream; the downstream stage must honour its own flush.
- Bubble masking:
  - out_ctrl = stored ctrl AND out_valid, bitwise, so a bubble never asserts register-write or memory-write controls.
  - out_data holds its last value when invalid; its content is don't-care.
- Stall counter:
  - Increments on every cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - stat_clr sets it to 0; if stat_clr coincides with a stall cycle, the result is 0.
  - Flush does not affect the counter.
- Stored data and ctrl registers load only on accept or skid-to-main transfer, with no enable toggling otherwise.

Decomposition:
- Shared package pipe_pkg holds:
  - default widths DATA_W_DEF and CTRL_W_DEF;
  - ctrl bit-index constants CTRL_REG_WE, CTRL_MEM_WE, CTRL_MEM_TYPE and CTRL_WB_SEL_LSB/MSB, so every stage instance slices ctrl identically.
- One natural sub-module: sat_counter (parameter CNT_W; ports inc and clr), reused by other performance counters.
- The skid slot stays inline; it is generated only when SKID=1.

Test Plan:
- Reset and fill: assert rst mid-cycle with main full -> out_valid=0 and out_ctrl=0 immediately. After release, in_ready=1; in_data=0x1234 with in_ctrl=0x3F accepted -> next cycle out_valid=1, out_data=0x1234, out_ctrl=0x3F.
- Backpressure (SKID=1): out_ready=0, send beats A=0x1 then B=0x2 -> in_ready falls after B. Raise out_ready -> A then B on consecutive cycles, no loss or duplication. stall_cnt equals the number of low out_ready cycles with out_valid high.
- Throughput (both SKID modes): 100 beats with out_ready tied high, counting values 0..99 -> output arrives in order, one per cycle after 1-cycle latency, and stall_cnt=0.
- Flush with both entries full, coinciding with in_valid=1 -> next cycle out_valid=0 and out_ctrl=0. The flushed-cycle input never appears; the following beat 0x55 appears normally.
- Saturation (CNT_W=4): hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15. stat_clr pulse during a stall cycle -> 0 next cycle, then increments from 1.
- Random stimulus: random in_valid/out_ready/flush against a scoreboard -> FIFO order holds, and out_ctrl is never nonzero while out_valid=0.
